// File: rtl/stage3_hazard_ctrl_if.sv
// Status and control bundle between the three pipeline stages and the hazard/redirect controller.
// master: the pipeline side that reports status; slave: the hazard controller.
interface stage3_hazard_ctrl_if;
  logic [4:0]  rs1_e;
  logic [4:0]  rs2_e;
  logic [4:0]  rd_m;
  logic        reg_write;
  logic        dren;
  logic        dwen;
  logic        csr_read;
  logic        valid_e;
  logic        valid_m;
  logic        i_mem_busy;
  logic        d_mem_busy;
  logic        ex_busy;
  logic        mispredict;
  logic        exception_m;
  logic        ret_m;
  logic        ifence;
  logic        fence_stall;
  logic        halt;
  logic [31:0] priv_vector;

  logic        pc_en;
  logic        npc_sel;
  logic        if_ex_stall;
  logic        ex_mem_stall;
  logic        if_ex_flush;
  logic        ex_mem_flush;
  logic        iren;
  logic        suppress_iren;
  logic        suppress_data;
  logic        rollback;
  logic        insert_priv_pc;
  logic [31:0] priv_pc;
  logic        halted;

  modport master (
    output rs1_e, rs2_e, rd_m, reg_write, dren, dwen, csr_read, valid_e, valid_m,
           i_mem_busy, d_mem_busy, ex_busy, mispredict, exception_m, ret_m,
           ifence, fence_stall, halt, priv_vector,
    input  pc_en, npc_sel, if_ex_stall, ex_mem_stall, if_ex_flush, ex_mem_flush,
           iren, suppress_iren, suppress_data, rollback, insert_priv_pc, priv_pc, halted
  );

  modport slave (
    input  rs1_e, rs2_e, rd_m, reg_write, dren, dwen, csr_read, valid_e, valid_m,
           i_mem_busy, d_mem_busy, ex_busy, mispredict, exception_m, ret_m,
           ifence, fence_stall, halt, priv_vector,
    output pc_en, npc_sel, if_ex_stall, ex_mem_stall, if_ex_flush, ex_mem_flush,
           iren, suppress_iren, suppress_data, rollback, insert_priv_pc, priv_pc, halted
  );
endinterface

// File: rtl/stage3_hazard_ctrl.sv
// Hazard and redirect controller for the three-stage pipeline: a small FSM sequences
// traps/returns, fence.i and halt around in-flight fetches; stall/flush decode is combinational.
module stage3_hazard_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input logic                  CLK,
  input logic                  nRST,
  stage3_hazard_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_RUN        = 2'd0,
    ST_TRAP_WAIT  = 2'd1,
    ST_FENCE_WAIT = 2'd2,
    ST_HALTED     = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_priv_pc;
  logic        w_load_priv;

  logic w_halt_ev;
  logic w_trap_ev;
  logic w_fence_ev;
  logic w_mispredict_ev;
  logic w_mem_stall;
  logic w_data_hazard;

  assign w_halt_ev       = bus.valid_m & bus.halt;
  assign w_trap_ev       = bus.valid_m & (bus.exception_m | bus.ret_m);
  assign w_fence_ev      = bus.valid_m & bus.ifence;
  assign w_mispredict_ev = bus.valid_m & bus.mispredict;
  assign w_mem_stall     = bus.valid_m & (bus.dren | bus.dwen) & bus.d_mem_busy;
  // Only loads and CSR reads resolve late enough to need a bubble; x0 never creates a dependency.
  assign w_data_hazard   = bus.valid_e & bus.valid_m & bus.reg_write & (bus.dren | bus.csr_read)
                         & (bus.rd_m != 5'd0) & ((bus.rd_m == bus.rs1_e) | (bus.rd_m == bus.rs2_e));

  assign bus.priv_pc = r_priv_pc;

  // Next-state and pipeline control decode from the current state and stage status.
  always_comb begin
    w_next_state       = r_state;
    w_load_priv        = 1'b0;
    bus.pc_en          = 1'b1;
    bus.npc_sel        = 1'b0;
    bus.if_ex_stall    = 1'b0;
    bus.ex_mem_stall   = 1'b0;
    bus.if_ex_flush    = 1'b0;
    bus.ex_mem_flush   = 1'b0;
    bus.iren           = 1'b1;
    bus.suppress_iren  = 1'b0;
    bus.suppress_data  = 1'b0;
    bus.rollback       = 1'b0;
    bus.insert_priv_pc = 1'b0;
    bus.halted         = 1'b0;
    case (r_state)
      ST_RUN: begin
        if (w_halt_ev) begin
          bus.if_ex_flush   = 1'b1;
          bus.ex_mem_flush  = 1'b1;
          bus.pc_en         = 1'b0;
          bus.suppress_data = 1'b1;
          w_next_state      = ST_HALTED;
        end else if (w_trap_ev) begin
          bus.if_ex_flush   = 1'b1;
          bus.ex_mem_flush  = 1'b1;
          bus.pc_en         = 1'b0;
          bus.suppress_data = 1'b1;
          w_load_priv       = 1'b1;
          w_next_state      = ST_TRAP_WAIT;
        end else if (w_fence_ev) begin
          bus.if_ex_flush  = 1'b1;
          bus.ex_mem_flush = 1'b1;
          bus.pc_en        = 1'b0;
          w_next_state     = ST_FENCE_WAIT;
        end else if (w_mispredict_ev) begin
          // A busy fetch cannot be redirected yet: hold the branch in mem and retry next cycle.
          bus.npc_sel      = 1'b1;
          bus.if_ex_flush  = 1'b1;
          bus.pc_en        = ~bus.i_mem_busy;
          bus.ex_mem_stall = bus.i_mem_busy;
          bus.ex_mem_flush = ~bus.i_mem_busy;
        end else if (w_mem_stall) begin
          bus.if_ex_stall  = 1'b1;
          bus.ex_mem_stall = 1'b1;
          bus.pc_en        = 1'b0;
        end else if (w_data_hazard || bus.ex_busy) begin
          bus.if_ex_stall  = 1'b1;
          bus.ex_mem_flush = 1'b1;
          bus.pc_en        = 1'b0;
        end else if (bus.i_mem_busy) begin
          bus.pc_en       = 1'b0;
          bus.if_ex_flush = 1'b1;
        end else begin
          bus.pc_en = 1'b1;
        end
      end
      ST_TRAP_WAIT: begin
        if (bus.i_mem_busy) begin
          bus.suppress_iren = 1'b1;
          bus.if_ex_flush   = 1'b1;
          bus.ex_mem_flush  = 1'b1;
          bus.pc_en         = 1'b0;
        end else begin
          bus.insert_priv_pc = 1'b1;
          w_next_state       = ST_RUN;
        end
      end
      ST_FENCE_WAIT: begin
        if (bus.fence_stall || bus.i_mem_busy) begin
          bus.suppress_iren = 1'b1;
          bus.if_ex_flush   = 1'b1;
          bus.ex_mem_flush  = 1'b1;
          bus.pc_en         = 1'b0;
        end else begin
          bus.rollback = 1'b1;
          w_next_state = ST_RUN;
        end
      end
      ST_HALTED: begin
        bus.pc_en        = 1'b0;
        bus.iren         = 1'b0;
        bus.if_ex_flush  = 1'b1;
        bus.ex_mem_flush = 1'b1;
        bus.halted       = 1'b1;
      end
      default: begin
        w_next_state = ST_RUN;
      end
    endcase
  end

  // State register and redirect-target capture.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state   <= ST_RUN;
      r_priv_pc <= RESET_VECTOR;
    end else begin
      r_state <= w_next_state;
      if (w_load_priv) begin
        r_priv_pc <= bus.priv_vector;
      end
    end
  end

endmodule

// File: tb/tb_stage3_hazard_ctrl.sv
// Self-checking bench for stage3_hazard_ctrl: directed scenarios plus randomized traffic,
// all compared against a rule-table reference model.
module tb_stage3_hazard_ctrl;

  localparam logic [31:0] RV = 32'h0000_0000;

  // Expected control vectors, bit order:
  // {pc_en,npc_sel,if_ex_stall,ex_mem_stall,if_ex_flush,ex_mem_flush,iren,sup_iren,sup_data,rollback,insert,halted}
  localparam logic [11:0] C_IDLE     = 12'h820;
  localparam logic [11:0] C_KILL     = 12'h0E8;
  localparam logic [11:0] C_FENCE    = 12'h0E0;
  localparam logic [11:0] C_MP_BUSY  = 12'h5A0;
  localparam logic [11:0] C_MP_GO    = 12'hCE0;
  localparam logic [11:0] C_MEMSTALL = 12'h320;
  localparam logic [11:0] C_BUBBLE   = 12'h260;
  localparam logic [11:0] C_IBUSY    = 12'h0A0;
  localparam logic [11:0] C_WAIT     = 12'h0F0;
  localparam logic [11:0] C_INSERT   = 12'h822;
  localparam logic [11:0] C_ROLLBACK = 12'h824;
  localparam logic [11:0] C_HALTED   = 12'h0C1;

  logic CLK = 1'b0;
  logic nRST;
  always #5 CLK = ~CLK;

  stage3_hazard_ctrl_if bus ();
  stage3_hazard_ctrl #(.RESET_VECTOR(RV)) dut (.CLK(CLK), .nRST(nRST), .bus(bus));

  int n_checks = 0;
  int n_pass   = 0;

  bit          m_halted, m_trap_pending, m_fence_pending;
  logic [31:0] m_pc;
  logic [11:0] last_ctrl;
  logic        prev_ins, prev_rb;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic set_idle();
    bus.rs1_e = 5'd0; bus.rs2_e = 5'd0; bus.rd_m = 5'd0;
    bus.reg_write = 1'b0; bus.dren = 1'b0; bus.dwen = 1'b0; bus.csr_read = 1'b0;
    bus.valid_e = 1'b0; bus.valid_m = 1'b0; bus.i_mem_busy = 1'b0; bus.d_mem_busy = 1'b0;
    bus.ex_busy = 1'b0; bus.mispredict = 1'b0; bus.exception_m = 1'b0; bus.ret_m = 1'b0;
    bus.ifence = 1'b0; bus.fence_stall = 1'b0; bus.halt = 1'b0; bus.priv_vector = 32'h0;
  endtask

  task automatic model_reset();
    m_halted = 1'b0; m_trap_pending = 1'b0; m_fence_pending = 1'b0; m_pc = RV;
  endtask

  function automatic logic [11:0] model_ctrl();
    logic [7:0] cond;
    int win;
    logic imb;
    imb = bus.i_mem_busy;
    if (m_halted) return C_HALTED;
    if (m_trap_pending) return imb ? C_WAIT : C_INSERT;
    if (m_fence_pending) return (bus.fence_stall || imb) ? C_WAIT : C_ROLLBACK;
    // Index 0 is the highest priority rule.
    cond[0] = bus.valid_m && bus.halt;
    cond[1] = bus.valid_m && (bus.exception_m || bus.ret_m);
    cond[2] = bus.valid_m && bus.ifence;
    cond[3] = bus.valid_m && bus.mispredict;
    cond[4] = bus.valid_m && (bus.dren || bus.dwen) && bus.d_mem_busy;
    cond[5] = bus.valid_e && bus.valid_m && bus.reg_write && (bus.dren || bus.csr_read)
              && bus.rd_m != 5'd0 && (bus.rd_m == bus.rs1_e || bus.rd_m == bus.rs2_e);
    cond[6] = bus.ex_busy;
    cond[7] = imb;
    win = -1;
    for (int i = 7; i >= 0; i--) if (cond[i]) win = i;
    case (win)
      0, 1:    return C_KILL;
      2:       return C_FENCE;
      3:       return imb ? C_MP_BUSY : C_MP_GO;
      4:       return C_MEMSTALL;
      5, 6:    return C_BUBBLE;
      7:       return C_IBUSY;
      default: return C_IDLE;
    endcase
  endfunction

  task automatic model_update();
    if (!nRST) model_reset();
    else if (m_halted) m_halted = 1'b1;
    else if (m_trap_pending) m_trap_pending = bus.i_mem_busy;
    else if (m_fence_pending) m_fence_pending = bus.fence_stall || bus.i_mem_busy;
    else if (bus.valid_m && bus.halt) m_halted = 1'b1;
    else if (bus.valid_m && (bus.exception_m || bus.ret_m)) begin
      m_trap_pending = 1'b1;
      m_pc = bus.priv_vector;
    end else if (bus.valid_m && bus.ifence) m_fence_pending = 1'b1;
  endtask

  // Called just after a falling edge with inputs already driven; checks, then advances one cycle.
  task automatic step(input string tag);
    logic [11:0] got;
    #1;
    if (!nRST) model_reset();
    got = {bus.pc_en, bus.npc_sel, bus.if_ex_stall, bus.ex_mem_stall, bus.if_ex_flush,
           bus.ex_mem_flush, bus.iren, bus.suppress_iren, bus.suppress_data, bus.rollback,
           bus.insert_priv_pc, bus.halted};
    check(tag, {20'h0, got}, {20'h0, model_ctrl()});
    check({tag, "_priv_pc"}, bus.priv_pc, m_pc);
    check({tag, "_pulse"}, {29'h0, bus.insert_priv_pc & prev_ins, bus.rollback & prev_rb,
                            bus.insert_priv_pc & bus.rollback}, 32'h0);
    prev_ins  = bus.insert_priv_pc;
    prev_rb   = bus.rollback;
    last_ctrl = got;
    @(posedge CLK);
    model_update();
    @(negedge CLK);
  endtask

  task automatic randomize_inputs();
    nRST            = ($urandom_range(49) != 0);
    bus.rs1_e       = 5'($urandom_range(3));
    bus.rs2_e       = 5'($urandom_range(3));
    bus.rd_m        = 5'($urandom_range(3));
    bus.reg_write   = 1'($urandom_range(1));
    bus.dren        = 1'($urandom_range(1));
    bus.dwen        = 1'($urandom_range(1));
    bus.csr_read    = 1'($urandom_range(1));
    bus.valid_e     = ($urandom_range(3) != 0);
    bus.valid_m     = ($urandom_range(3) != 0);
    bus.i_mem_busy  = 1'($urandom_range(1));
    bus.d_mem_busy  = 1'($urandom_range(1));
    bus.ex_busy     = ($urandom_range(4) == 0);
    bus.mispredict  = ($urandom_range(5) == 0);
    bus.exception_m = ($urandom_range(9) == 0);
    bus.ret_m       = ($urandom_range(9) == 0);
    bus.ifence      = ($urandom_range(9) == 0);
    bus.fence_stall = 1'($urandom_range(1));
    bus.halt        = ($urandom_range(99) == 0);
    bus.priv_vector = $urandom;
  endtask

  initial begin
    prev_ins = 1'b0; prev_rb = 1'b0;
    model_reset();
    nRST = 1'b0;
    set_idle();
    @(negedge CLK);
    step("reset");
    check("reset_vec", {20'h0, last_ctrl}, {20'h0, C_IDLE});
    nRST = 1'b1;

    // Load-use bubble, then the same pattern targeting x0.
    bus.valid_e = 1'b1; bus.valid_m = 1'b1; bus.dren = 1'b1; bus.reg_write = 1'b1;
    bus.rd_m = 5'd5; bus.rs1_e = 5'd5;
    step("load_use");
    check("load_use_vec", {20'h0, last_ctrl}, {20'h0, C_BUBBLE});
    bus.rd_m = 5'd0; bus.rs1_e = 5'd0;
    step("load_use_x0");
    check("load_use_x0_vec", {20'h0, last_ctrl}, {20'h0, C_IDLE});

    // Trap with the fetch busy for three more cycles.
    set_idle();
    bus.valid_m = 1'b1; bus.exception_m = 1'b1; bus.priv_vector = 32'h8000_0100; bus.i_mem_busy = 1'b1;
    step("trap_T");
    check("trap_T_supdata", {31'h0, last_ctrl[3]}, 32'h1);
    bus.valid_m = 1'b0; bus.exception_m = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      step("trap_busy");
      check("trap_no_insert", {31'h0, last_ctrl[1]}, 32'h0);
    end
    bus.i_mem_busy = 1'b0;
    step("trap_T4");
    check("trap_T4_insert", {20'h0, last_ctrl}, {20'h0, C_INSERT});
    check("trap_priv_pc", bus.priv_pc, 32'h8000_0100);
    step("trap_after");

    // Fence with the cache flush running through T+5.
    bus.valid_m = 1'b1; bus.ifence = 1'b1; bus.fence_stall = 1'b1;
    step("fence_T");
    bus.valid_m = 1'b0; bus.ifence = 1'b0;
    for (int k = 1; k <= 5; k++) begin
      step("fence_wait");
      check("fence_sup_iren", {31'h0, last_ctrl[4]}, 32'h1);
    end
    bus.fence_stall = 1'b0;
    step("fence_T6");
    check("fence_rollback", {20'h0, last_ctrl}, {20'h0, C_ROLLBACK});
    step("fence_after");
    check("fence_one_pulse", {31'h0, last_ctrl[2]}, 32'h0);

    // Mispredict held off by a busy fetch.
    bus.valid_m = 1'b1; bus.mispredict = 1'b1; bus.i_mem_busy = 1'b1;
    step("mp_busy0");
    step("mp_busy1");
    check("mp_busy_pc_en", {31'h0, last_ctrl[11]}, 32'h0);
    bus.i_mem_busy = 1'b0;
    step("mp_go");
    check("mp_go_vec", {20'h0, last_ctrl}, {20'h0, C_MP_GO});

    // Reset while waiting out a trap.
    set_idle();
    bus.valid_m = 1'b1; bus.ret_m = 1'b1; bus.priv_vector = 32'h0000_4440; bus.i_mem_busy = 1'b1;
    step("rst_trap_T");
    bus.valid_m = 1'b0; bus.ret_m = 1'b0;
    step("rst_trap_wait");
    bus.i_mem_busy = 1'b0; nRST = 1'b0;
    step("rst_mid");
    check("rst_mid_no_insert", {20'h0, last_ctrl}, {20'h0, C_IDLE});
    check("rst_mid_priv_pc", bus.priv_pc, RV);
    nRST = 1'b1;
    step("rst_mid_after");

    // Halt beats trap and mispredict in the same cycle.
    bus.valid_m = 1'b1; bus.halt = 1'b1; bus.exception_m = 1'b1; bus.mispredict = 1'b1;
    bus.priv_vector = 32'h1234_5678;
    step("prio_T");
    set_idle();
    for (int k = 0; k < 4; k++) step("prio_halted");
    check("prio_halted_vec", {20'h0, last_ctrl}, {20'h0, C_HALTED});
    nRST = 1'b0;
    step("prio_reset");
    nRST = 1'b1;

    for (int n = 0; n < 3000; n++) begin
      randomize_inputs();
      step("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
